// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - RV32I conditional-branch resolver with a two-stage valid/ready pipeline
// S1 evaluates the condition and target; S2 holds the redirect record handed to fetch.
module branch_resolver #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_func3,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [XLEN-1:0]  out_next_pc,
  output logic             out_misalign,
  output logic             out_illegal,
  output logic [CNT_W-1:0] cnt_resolved,
  output logic [CNT_W-1:0] cnt_taken
);

  logic            s1_valid_q, s1_valid_d;
  logic [XLEN-1:0] s1_pc4_q, s1_pc4_d;
  logic [XLEN-1:0] s1_tgt_q, s1_tgt_d;
  logic            s1_cond_q, s1_cond_d;
  logic            s1_ill_q, s1_ill_d;

  logic            out_valid_q, out_valid_d;
  logic            out_taken_q, out_taken_d;
  logic [XLEN-1:0] out_next_pc_q, out_next_pc_d;
  logic            out_misalign_q, out_misalign_d;
  logic            out_illegal_q, out_illegal_d;

  logic [CNT_W-1:0] cnt_resolved_q, cnt_resolved_d;
  logic [CNT_W-1:0] cnt_taken_q, cnt_taken_d;

  logic cond, illegal;
  logic s2_free, in_hs, out_hs, squash, s1_adv;

  always_comb begin
    cond    = 1'b0;
    illegal = 1'b0;
    case (in_func3)
      3'b000:  cond = (in_rs1 == in_rs2);
      3'b001:  cond = (in_rs1 != in_rs2);
      3'b100:  cond = ($signed(in_rs1) <  $signed(in_rs2));
      3'b101:  cond = ($signed(in_rs1) >= $signed(in_rs2));
      3'b110:  cond = (in_rs1 <  in_rs2);
      3'b111:  cond = (in_rs1 >= in_rs2);
      default: illegal = 1'b1;
    endcase
  end

  assign out_hs   = out_valid_q & out_ready;
  assign s2_free  = !out_valid_q | out_ready;
  assign in_ready = !s1_valid_q | s2_free;
  assign in_hs    = in_valid & in_ready;
  // A taken redirect makes everything younger wrong-path, including this cycle's input.
  assign squash   = out_hs & out_taken_q;
  assign s1_adv   = s1_valid_q & s2_free & !squash;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_pc4_d   = s1_pc4_q;
    s1_tgt_d   = s1_tgt_q;
    s1_cond_d  = s1_cond_q;
    s1_ill_d   = s1_ill_q;
    if (squash) begin
      s1_valid_d = 1'b0;
    end else if (in_hs) begin
      s1_valid_d = 1'b1;
      s1_pc4_d   = in_pc + XLEN'(4);
      s1_tgt_d   = in_pc + in_imm;
      s1_cond_d  = cond;
      s1_ill_d   = illegal;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    out_valid_d    = out_valid_q;
    out_taken_d    = out_taken_q;
    out_next_pc_d  = out_next_pc_q;
    out_misalign_d = out_misalign_q;
    out_illegal_d  = out_illegal_q;
    if (squash) begin
      out_valid_d = 1'b0;
    end else if (s1_adv) begin
      out_valid_d    = 1'b1;
      out_taken_d    = s1_cond_q;
      out_next_pc_d  = s1_cond_q ? s1_tgt_q : s1_pc4_q;
      out_misalign_d = s1_cond_q & (s1_tgt_q[1:0] != 2'b00);
      out_illegal_d  = s1_ill_q;
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    cnt_resolved_d = cnt_resolved_q;
    cnt_taken_d    = cnt_taken_q;
    if (out_hs && !out_illegal_q) cnt_resolved_d = cnt_resolved_q + CNT_W'(1);
    if (out_hs && out_taken_q)    cnt_taken_d    = cnt_taken_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q     <= 1'b0;
      s1_pc4_q       <= '0;
      s1_tgt_q       <= '0;
      s1_cond_q      <= 1'b0;
      s1_ill_q       <= 1'b0;
      out_valid_q    <= 1'b0;
      out_taken_q    <= 1'b0;
      out_next_pc_q  <= '0;
      out_misalign_q <= 1'b0;
      out_illegal_q  <= 1'b0;
      cnt_resolved_q <= '0;
      cnt_taken_q    <= '0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_pc4_q       <= s1_pc4_d;
      s1_tgt_q       <= s1_tgt_d;
      s1_cond_q      <= s1_cond_d;
      s1_ill_q       <= s1_ill_d;
      out_valid_q    <= out_valid_d;
      out_taken_q    <= out_taken_d;
      out_next_pc_q  <= out_next_pc_d;
      out_misalign_q <= out_misalign_d;
      out_illegal_q  <= out_illegal_d;
      cnt_resolved_q <= cnt_resolved_d;
      cnt_taken_q    <= cnt_taken_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_taken    = out_taken_q;
  assign out_next_pc  = out_next_pc_q;
  assign out_misalign = out_misalign_q;
  assign out_illegal  = out_illegal_q;
  assign cnt_resolved = cnt_resolved_q;
  assign cnt_taken    = cnt_taken_q;

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - directed self-checking bench for branch_resolver
module tb_branch_resolver;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [2:0]  in_func3;
  logic [31:0] in_rs1, in_rs2, in_pc, in_imm;
  logic        out_valid, out_ready, out_taken, out_misalign, out_illegal;
  logic [31:0] out_next_pc, cnt_resolved, cnt_taken;

  int n_pass = 0;
  int n_total = 0;

  branch_resolver #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_func3(in_func3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_next_pc(out_next_pc), .out_misalign(out_misalign), .out_illegal(out_illegal),
    .cnt_resolved(cnt_resolved), .cnt_taken(cnt_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] imm);
    in_valid = 1'b1;
    in_func3 = f3;
    in_rs1   = a;
    in_rs2   = b;
    in_pc    = pc;
    in_imm   = imm;
  endtask

  // One op through an idle pipeline with out_ready held high.
  task automatic one_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm,
                        input logic e_tak, input logic [31:0] e_npc, input logic e_mis,
                        input logic e_ill, input logic [31:0] e_res, input logic [31:0] e_tk);
    offer(f3, a, b, pc, imm);
    step();
    in_valid = 1'b0;
    step();
    check({tag, ".valid"}, out_valid, 1);
    check({tag, ".taken"}, out_taken, e_tak);
    check({tag, ".next_pc"}, out_next_pc, e_npc);
    check({tag, ".misalign"}, out_misalign, e_mis);
    check({tag, ".illegal"}, out_illegal, e_ill);
    step();
    check({tag, ".drained"}, out_valid, 0);
    check({tag, ".cnt_resolved"}, cnt_resolved, e_res);
    check({tag, ".cnt_taken"}, cnt_taken, e_tk);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_func3 = 3'b000; in_rs1 = '0; in_rs2 = '0; in_pc = '0; in_imm = '0;
    out_ready = 1'b1;
    #12;
    check("rst.out_valid", out_valid, 0);
    check("rst.in_ready", in_ready, 1);
    check("rst.next_pc", out_next_pc, 0);
    check("rst.cnt_resolved", cnt_resolved, 0);
    check("rst.cnt_taken", cnt_taken, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    one_op("beq",   3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1, 32'h120, 0, 0, 1, 1);
    one_op("blt",   3'b100, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h40, 1, 32'h240, 0, 0, 2, 2);
    one_op("bltu",  3'b110, 32'hFFFFFFFF, 32'd1, 32'h300, 32'h40, 0, 32'h304, 0, 0, 3, 2);
    one_op("wrap",  3'b000, 32'd9, 32'd9, 32'hFFFFFFF0, 32'h20, 1, 32'h10, 0, 0, 4, 3);
    one_op("misal", 3'b000, 32'd1, 32'd1, 32'h400, 32'h2, 1, 32'h402, 1, 0, 5, 4);
    one_op("illeg", 3'b010, 32'd1, 32'd1, 32'h500, 32'h20, 0, 32'h504, 0, 1, 5, 4);
    one_op("bgeu",  3'b111, 32'd3, 32'd7, 32'h800, 32'h40, 0, 32'h804, 0, 0, 6, 4);

    // Backpressure: three not-taken BNEs with fetch stalled.
    out_ready = 1'b0;
    offer(3'b001, 32'd7, 32'd7, 32'h600, 32'h80);
    step();
    offer(3'b001, 32'd7, 32'd7, 32'h610, 32'h80);
    step();
    check("bp.in_ready_low", in_ready, 0);
    offer(3'b001, 32'd7, 32'd7, 32'h620, 32'h80);
    for (int i = 0; i < 3; i++) begin
      check("bp.hold_valid", out_valid, 1);
      check("bp.hold_npc", out_next_pc, 32'h604);
      check("bp.hold_in_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("bp.rec2", out_next_pc, 32'h614);
    step();
    check("bp.rec3", out_next_pc, 32'h624);
    check("bp.rec3_valid", out_valid, 1);
    step();
    check("bp.empty", out_valid, 0);
    check("bp.cnt_resolved", cnt_resolved, 9);
    check("bp.cnt_taken", cnt_taken, 4);

    // Squash: taken BGE in S2, younger op in S1, third op offered on the redirect cycle.
    out_ready = 1'b0;
    offer(3'b101, 32'd5, 32'd5, 32'h700, 32'h100);
    step();
    offer(3'b000, 32'd1, 32'd1, 32'h710, 32'h10);
    step();
    offer(3'b000, 32'd1, 32'd1, 32'h720, 32'h10);
    check("sq.s2_taken", out_taken, 1);
    check("sq.s2_npc", out_next_pc, 32'h800);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("sq.no_younger", out_valid, 0);
      step();
    end
    check("sq.cnt_resolved", cnt_resolved, 10);
    check("sq.cnt_taken", cnt_taken, 5);

    // Asynchronous reset with both stages full.
    out_ready = 1'b0;
    offer(3'b000, 32'd2, 32'd2, 32'h900, 32'h8);
    step();
    offer(3'b001, 32'd2, 32'd2, 32'h910, 32'h8);
    step();
    in_valid = 1'b0;
    check("ar.full_valid", out_valid, 1);
    check("ar.full_in_ready", in_ready, 0);
    #2;
    rst = 1'b1;
    #1;
    check("ar.out_valid", out_valid, 0);
    check("ar.in_ready", in_ready, 1);
    check("ar.cnt_resolved", cnt_resolved, 0);
    check("ar.cnt_taken", cnt_taken, 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    check("ar.stays_empty", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
